// File: rtl/s_link_pkg.sv
// Shared constants and control-FSM state type for the serial link receiver.
package s_link_pkg;

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned DATA_W    = 18;
    localparam int unsigned PKT_NUM   = 8;
    localparam int unsigned FRAME_LEN = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit,
        StDone
    } state_e;

endpackage

// File: rtl/s_deser.sv
// Frame deserializer: shifts sd in while sen is low and flags the frame end as
// well-formed (exactly FrameLen bits) or malformed (any other non-zero count).
module s_deser
    import s_link_pkg::*;
#(
    parameter int unsigned FrameLen = s_link_pkg::FRAME_LEN,
    localparam int unsigned BcntW   = $clog2(FrameLen + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sen,
    input  logic                sd,
    output logic                frame_ok,
    output logic                frame_bad,
    output logic [FrameLen-1:0] word
);

    localparam logic [BcntW-1:0] BcntFull = BcntW'(FrameLen);
    // Saturation value: one past a full frame, so overlong frames never wrap back to "full".
    localparam logic [BcntW-1:0] BcntSat  = BcntW'(FrameLen + 1);

    logic [FrameLen-1:0] sreg_q, sreg_d;
    logic [BcntW-1:0]    bcnt_q, bcnt_d;

    // Next-state for the shift register and bit counter, plus frame-end classification.
    always_comb begin
        sreg_d = sreg_q;
        bcnt_d = bcnt_q;
        if (!sen) begin
            sreg_d = {sreg_q[FrameLen-2:0], sd};
            if (bcnt_q != BcntSat) begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else begin
            bcnt_d = '0;
        end
        frame_ok  = sen && (bcnt_q == BcntFull);
        frame_bad = sen && (bcnt_q != '0) && (bcnt_q != BcntFull);
        word      = sreg_q;
    end

    // Shift register and bit counter, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg_q <= '0;
            bcnt_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            bcnt_q <= bcnt_d;
        end
    end

endmodule

// File: rtl/s2_receiver.sv
// Serial packet receiver: deserializes {addr, data} frames and writes each accepted
// word into RB2 with a one-cycle low RB2_RW strobe; S2_done after PKT_NUM packets.
module s2_receiver
    import s_link_pkg::*;
#(
    parameter int unsigned ADDR_W  = s_link_pkg::ADDR_W,
    parameter int unsigned DATA_W  = s_link_pkg::DATA_W,
    parameter int unsigned PKT_NUM = s_link_pkg::PKT_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              S2_done,
    output logic              frame_err
);

    localparam int unsigned FrameLen = ADDR_W + DATA_W;
    localparam int unsigned PcntW    = ADDR_W + 1;
    localparam logic [PcntW-1:0] PktMax = PcntW'(PKT_NUM);

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [PcntW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                err_q, err_d;

    logic                frame_ok;
    logic                frame_bad;
    logic [FrameLen-1:0] word;
    logic                live;

    // RB2 is write-only from this block; the read port is intentionally unused.
    logic unused_rb2_q;
    assign unused_rb2_q = ^RB2_Q;

    s_deser #(
        .FrameLen (FrameLen)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .sen       (sen),
        .sd        (sd),
        .frame_ok  (frame_ok),
        .frame_bad (frame_bad),
        .word      (word)
    );

    // Next-state: output registers, packet count, error flag and control FSM.
    always_comb begin
        state_d   = state_q;
        rw_d      = 1'b1;
        addr_d    = addr_q;
        data_d    = data_q;
        pkt_cnt_d = pkt_cnt_q;
        err_d     = err_q;

        // Once done, frames are still shifted by the deserializer but have no effect.
        live = (state_q != StDone);

        if (live && frame_ok) begin
            rw_d   = 1'b0;
            addr_d = word[FrameLen-1 -: ADDR_W];
            data_d = word[DATA_W-1:0];
            if (pkt_cnt_q != PktMax) begin
                pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
        end
        if (live && frame_bad) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (!sen) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (sen) begin
                    state_d = frame_ok ? StCommit : StIdle;
                end
            end
            StCommit: begin
                // Strobe cycle; a new frame may already be shifting in.
                if (pkt_cnt_q == PktMax) begin
                    state_d = StDone;
                end else if (!sen) begin
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            pkt_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_q     <= err_d;
        end
    end

    assign RB2_RW    = rw_q;
    assign RB2_A     = addr_q;
    assign RB2_D     = data_q;
    assign S2_done   = (state_q == StDone);
    assign frame_err = err_q;

endmodule

// File: doc/s2_receiver.md
# s2_receiver

Serial packet receiver and register-bank writer, directly downstream of the RB1 serial transmitter. Deserializes packets framed by `sen` on `sd`: a 3-bit address, then an 18-bit data word. Writes each word into register bank RB2 at that address. Raises `S2_done` after the full set of packets has been written.

## Interface
- `ADDR_W`, default 3: packet address bits; RB2 depth is 2^ADDR_W.
- `DATA_W`, default 18: packet data bits; RB2 word width.
- `PKT_NUM`, default 8: number of packets per transfer.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `sen`  in  1  frame enable, active-low; driven by upstream on negedge.
- `sd`  in  1  serial data, valid while `sen`=0, MSB first.
- `RB2_RW`  out  1  RB2 control: 1 = read/idle, 0 = write.
- `RB2_A`  out  ADDR_W  RB2 write address.
- `RB2_D`  out  DATA_W  RB2 write data.
- `RB2_Q`  in  DATA_W  RB2 read port; ignored.
- `S2_done`  out  1  transfer complete; sticky.
- `frame_err`  out  1  sticky flag: a malformed frame was discarded.

## Operation
- Packet format on `sd` while `sen`=0: ADDR_W address bits MSB first, then DATA_W data bits MSB first. 21 bits at defaults.
- Shift path: at each posedge with `sen`=0, shift `sd` into a (ADDR_W+DATA_W)-bit shift register. Increment bit counter `bcnt` (5 bits), saturating at ADDR_W+DATA_W+1.
- Frame end: at a posedge with `sen`=1 and `bcnt`≠0:
  - If `bcnt`==ADDR_W+DATA_W: load `RB2_A` with the upper ADDR_W bits, load `RB2_D` with the lower DATA_W bits, drive `RB2_RW`←0, increment `pkt_cnt`.
  - Otherwise: no write; `frame_err`←1.
  - In both cases `bcnt`←0.
- Write strobe: `RB2_RW` is low for exactly one cycle per accepted packet. `RB2_A`/`RB2_D` hold their values until the next accepted packet.
- Control FSM:
  - IDLE: `sen`=1, `bcnt`=0. Go to SHIFT on `sen`=0.
  - SHIFT: `sen`=0. Go to COMMIT on `sen`=1.
  - COMMIT: one cycle. Go to SHIFT if `sen`=0, else IDLE. If `pkt_cnt`==PKT_NUM, go to DONE.
  - DONE: absorbing until reset.
- The shift register and the output registers are separate. A new frame starting on the cycle immediately after a frame end (single-cycle `sen` high gap) is captured while the write strobe is active.
- `pkt_cnt` is ADDR_W+1 bits and does not wrap.
- In DONE, further frames are ignored: no writes, no error.
- Duplicate addresses are accepted; the last write wins. No address-order check.

## Timing
- Reset (`rst`=0 at posedge), all outputs and state:
  - `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `S2_done`=0, `frame_err`=0.
  - `bcnt`=0, `pkt_cnt`=0, FSM=IDLE.
- Reset mid-frame discards the partial packet. A frame already in progress when reset releases is counted as malformed only if `sen` is seen high with `bcnt`≠0.
- Latency: `RB2_RW` goes low at the first posedge with `sen`=1 after the last data bit, and returns high one posedge later.
- `S2_done` rises at the posedge where the PKT_NUM-th strobe ends, i.e. together with `RB2_RW` returning to 1.
- Minimum inter-frame gap: one cycle of `sen`=1.
- `sen` and `sd` are sampled at posedge; upstream changes them on negedge, giving half a cycle of setup.

## Structure
- Shared package `s_link_pkg`:
  - constants ADDR_W, DATA_W, PKT_NUM, FRAME_LEN = ADDR_W+DATA_W;
  - FSM state enum (IDLE, SHIFT, COMMIT, DONE).
- Natural sub-module: `s_deser`, containing the shift register and `bcnt` and producing `frame_ok` / `frame_bad` pulses with the parallel word. The top level holds the FSM, the output registers and `pkt_cnt`.

## Test plan
- Single frame: addr 3'b101, data 18'h2A5C3, then `sen`=1 → one-cycle `RB2_RW`=0 with `RB2_A`=5, `RB2_D`=18'h2A5C3; `S2_done`=0.
- Eight back-to-back frames, addr 0..7, one-cycle gaps, data = addr×18'h1111 → eight strobes, correct writes, `S2_done`=1 the cycle after the 8th strobe, `frame_err`=0.
- Short frame (20 bits) then valid frame addr 2 → no write for the first, `frame_err`=1, second written to addr 2; `pkt_cnt`=1.
- Long frame (22 bits) → no write, `frame_err`=1, `bcnt` saturates without wrap.
- Reset asserted after 10 bits of a frame, released, then one full frame addr 6 → only the addr 6 write occurs; all outputs at reset values in between.
- Ninth frame after `S2_done` → no strobe, `RB2_A`/`RB2_D` unchanged, `S2_done` stays 1.
